// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite row serializer: FSM state encoding,
// rows per sprite and the pixel-counter width.
package sprite_pkg;

  localparam int SPRITE_DATA_WIDTH = 96;
  localparam int ROWS_PER_SPRITE   = 96;
  localparam int CNT_W             = $clog2(SPRITE_DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } sprite_state_e;

endpackage

// File: rtl/sprite_row_serializer.sv
// Fetches one 96-pixel sprite row from a registered-read ROM and streams it out
// one pixel per valid/ready handshake. Optional macro SPRITE_MIRROR_EN adds req_mirror.
module sprite_row_serializer
  import sprite_pkg::*;
#(
  parameter int DATA_WIDTH  = SPRITE_DATA_WIDTH,
  parameter int ADDR_WIDTH  = 12,
  parameter int SPRITE_ID_W = 5,
  parameter int ROW_W       = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [SPRITE_ID_W-1:0] req_sprite,
  input  logic [ROW_W-1:0]       req_row,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_q,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic                   pix_data,
  output logic                   pix_last,
`ifdef SPRITE_MIRROR_EN
  input  logic                   req_mirror,
`endif
  output logic                   row_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never depends on ready, and data/last hold while valid && !ready.

  localparam logic [ROW_W-1:0] MAX_ROW = ROW_W'(ROWS_PER_SPRITE - 1);

  sprite_state_e          state;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   fire;
  logic                   row_oob;
  logic [ROW_W-1:0]       row_clamped;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic                   pix_bit;

  assign req_ready   = (state == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign pix_valid   = (state == ST_SHIFT);
  assign fire        = pix_valid && pix_ready;
  assign row_oob     = (req_row > MAX_ROW);
  assign row_clamped = row_oob ? MAX_ROW : req_row;
  assign addr_next   = ADDR_WIDTH'(req_sprite) * ADDR_WIDTH'(ROWS_PER_SPRITE)
                     + ADDR_WIDTH'(row_clamped);

`ifdef SPRITE_MIRROR_EN
  logic mirror_q;
  assign pix_bit = mirror_q ? shreg[0] : shreg[DATA_WIDTH-1];
`else
  assign pix_bit = shreg[DATA_WIDTH-1];
`endif

  assign pix_data = pix_valid && pix_bit;
  assign pix_last = pix_valid && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      shreg    <= '0;
      cnt      <= '0;
      row_err  <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rom_addr <= addr_next;
            if (row_oob) row_err <= 1'b1;
`ifdef SPRITE_MIRROR_EN
            mirror_q <= req_mirror;
`endif
            state <= ST_FETCH;
          end
        end
        // ROM samples rom_addr on this edge; its output is valid during LOAD.
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          shreg <= rom_q;
          cnt   <= CNT_W'(DATA_WIDTH - 1);
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (fire) begin
`ifdef SPRITE_MIRROR_EN
            shreg <= mirror_q ? (shreg >> 1) : (shreg << 1);
`else
            shreg <= shreg << 1;
`endif
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_serializer.sv
// Bench for sprite_row_serializer with a registered-read ROM model; expected pixel
// streams come from the ROM image and the address rule, kept in a scoreboard queue.
module tb_sprite_row_serializer;

  localparam int DW = 96;
  localparam int AW = 12;
  localparam int SW = 5;
  localparam int RW = 7;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_sprite;
  logic [RW-1:0] req_row;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_data;
  logic          pix_last;
  logic          req_mirror;
  logic          row_err;

  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  logic          exp_q[$];
  int            n_vec;
  int            n_err;
  logic          err_exp;

  sprite_row_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sprite (req_sprite),
    .req_row    (req_row),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
`ifdef SPRITE_MIRROR_EN
    .req_mirror (req_mirror),
`endif
    .row_err    (row_err)
  );

  // Clock and ROM model (registered read, one-cycle latency)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  function automatic int model_addr(input int spr, input int row);
    int r;
    r = (row >= 96) ? 95 : row;
    return spr * 96 + r;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_sprite = '0;
    req_row = '0;
    req_mirror = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    err_exp = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request at a negedge in IDLE and drain the row. abort_at >= 0 pulses
  // reset once that many pixels have been accepted. Returns at a negedge.
  task automatic do_row(input int spr, input int row, input logic mir,
                        input int rdy_pct, input int abort_at);
    logic [DW-1:0] word;
    logic          eff_mir;
    int            addr;
    int            got;
    int            cyc;
`ifdef SPRITE_MIRROR_EN
    eff_mir = mir;
`else
    eff_mir = 1'b0;
`endif
    addr = model_addr(spr, row);
    word = rom_mem[addr];
    exp_q.delete();
    for (int i = 0; i < DW; i++) exp_q.push_back(eff_mir ? word[i] : word[DW-1-i]);
    if (row >= 96) err_exp = 1'b1;

    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    end
    req_valid = 1'b1; req_sprite = SW'(spr); req_row = RW'(row); req_mirror = mir;
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++;
    if (rom_addr !== AW'(addr)) begin
      n_err++; $display("FAIL rom_addr: got %0d expected %0d", rom_addr, addr);
    end
    n_vec++;
    if (req_ready !== 1'b0 || pix_valid !== 1'b0) begin
      n_err++; $display("FAIL fetch_state: got ready=%b valid=%b expected 0 0", req_ready, pix_valid);
    end
    n_vec++;
    if (row_err !== err_exp) begin
      n_err++; $display("FAIL row_err: got %b expected %b", row_err, err_exp);
    end
    @(negedge clk);
    n_vec++;
    if (pix_valid !== 1'b0 || pix_data !== 1'b0) begin
      n_err++; $display("FAIL load_state: got valid=%b data=%b expected 0 0", pix_valid, pix_data);
    end
    @(negedge clk);

    got = 0;
    cyc = 0;
    while (got < DW && cyc < 2000) begin
      if (abort_at >= 0 && got == abort_at) begin
        rst_n = 1'b0;
        pix_ready = 1'b0;
        #1;
        n_vec++;
        if (pix_valid !== 1'b0 || req_ready !== 1'b1 || rom_addr !== '0 || pix_last !== 1'b0) begin
          n_err++; $display("FAIL abort_reset: got valid=%b ready=%b addr=%0d last=%b expected 0 1 0 0",
                            pix_valid, req_ready, rom_addr, pix_last);
        end
        @(negedge clk);
        n_vec++;
        if (pix_valid !== 1'b0 || row_err !== 1'b0) begin
          n_err++; $display("FAIL abort_hold: got valid=%b row_err=%b expected 0 0", pix_valid, row_err);
        end
        rst_n = 1'b1;
        err_exp = 1'b0;
        exp_q.delete();
        @(negedge clk);
        return;
      end
      n_vec++;
      if (pix_valid !== 1'b1 || pix_data !== exp_q[0] || pix_last !== (exp_q.size() == 1)) begin
        n_err++; $display("FAIL pixel_%0d: got valid=%b data=%b last=%b expected 1 %b %b",
                          got, pix_valid, pix_data, pix_last, exp_q[0], (exp_q.size() == 1));
      end
      pix_ready = ($urandom_range(99) < rdy_pct);
      @(posedge clk);
      if (pix_ready) begin
        void'(exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    pix_ready = 1'b0;
    n_vec++;
    if (got != DW) begin
      n_err++; $display("FAIL handshake_count: got %0d expected %0d", got, DW);
    end
    n_vec++;
    if (pix_valid !== 1'b0 || req_ready !== 1'b1 || pix_data !== 1'b0 || pix_last !== 1'b0) begin
      n_err++; $display("FAIL row_end_idle: got valid=%b ready=%b data=%b last=%b expected 0 1 0 0",
                        pix_valid, req_ready, pix_data, pix_last);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (req_ready !== 1'b1 || pix_valid !== 1'b0 || rom_addr !== '0 ||
        pix_data !== 1'b0 || pix_last !== 1'b0 || row_err !== 1'b0) begin
      n_err++; $display("FAIL reset_state: got ready=%b valid=%b addr=%0d data=%b last=%b err=%b expected 1 0 0 0 0 0",
                        req_ready, pix_valid, rom_addr, pix_data, pix_last, row_err);
    end
  endtask

  task automatic test_basic();
    do_row(0, 0, 1'b0, 100, -1);
    n_vec++;
    if (rom_addr !== 12'd0) begin
      n_err++; $display("FAIL basic_addr: got %0d expected 0", rom_addr);
    end
  endtask

  task automatic test_addr();
    do_row(2, 5, 1'b0, 100, -1);
    n_vec++;
    if (rom_addr !== 12'd197) begin
      n_err++; $display("FAIL addr_2_5: got %0d expected 197", rom_addr);
    end
    do_row(31, 95, 1'b0, 80, -1);
    n_vec++;
    if (rom_addr !== 12'd3071) begin
      n_err++; $display("FAIL addr_31_95: got %0d expected 3071", rom_addr);
    end
  endtask

  task automatic test_row_err();
    do_row(7, 100, 1'b0, 100, -1);
    n_vec++;
    if (rom_addr !== 12'd767 || row_err !== 1'b1) begin
      n_err++; $display("FAIL row_clamp: got addr=%0d err=%b expected 767 1", rom_addr, row_err);
    end
    do_row(3, 10, 1'b0, 100, -1);
    do_row(12, 127, 1'b0, 100, -1);
    do_row(4, 1, 1'b0, 100, -1);
    n_vec++;
    if (row_err !== 1'b1) begin
      n_err++; $display("FAIL row_err_sticky: got %b expected 1", row_err);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++)
      do_row($urandom_range(31), $urandom_range(95), 1'b0, 50, -1);
  endtask

  task automatic test_reset_abort();
    do_row(9, 33, 1'b0, 70, 40);
    do_row(9, 33, 1'b0, 60, -1);
  endtask

  task automatic test_mirror();
`ifdef SPRITE_MIRROR_EN
    logic [DW-1:0] saved;
    saved = rom_mem[model_addr(1, 1)];
    rom_mem[model_addr(1, 1)] = 96'h1;
    do_row(1, 1, 1'b1, 100, -1);
    rom_mem[model_addr(1, 1)] = saved;
    for (int k = 0; k < 3; k++)
      do_row($urandom_range(31), $urandom_range(95), 1'($urandom_range(1)), 50, -1);
`endif
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++)
      do_row($urandom_range(31), $urandom_range(127), 1'($urandom_range(1)), 90, -1);
  endtask

  initial begin
    logic [DW-1:0] w0;
    n_vec = 0;
    n_err = 0;
    err_exp = 1'b0;
    for (int a = 0; a < (1 << AW); a++)
      rom_mem[a] = {$urandom, $urandom, $urandom};
    w0 = '0;
    w0[DW-1] = 1'b1;
    w0[0] = 1'b1;
    rom_mem[0] = w0;

    test_reset();
    test_basic();
    test_addr();
    test_row_err();
    test_stall();
    test_reset_abort();
    test_mirror();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
